// File: rtl/rr_mux_pkg.sv
// Shared types and the round-robin pick function for rr_mux_arbiter.
// Define RR_MUX_FIXED_PRIO_EN to make the top use fixed priority (search starts at 0).
package rr_mux_pkg;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  typedef logic [$clog2(N_DEF)-1:0] idx_t;

  typedef struct packed {
    logic                 any;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // First set bit of req at or after ptr, wrapping modulo n (ptr must be < n).
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]     req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   n);
    pick_t              r;
    logic [MAX_IDX_W:0] j;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        j = {1'b0, ptr} + (MAX_IDX_W+1)'(k);
        if (j >= (MAX_IDX_W+1)'(n)) begin
          j = j - (MAX_IDX_W+1)'(n);
        end
        if (!r.any && req[j[MAX_IDX_W-1:0]]) begin
          r.any = 1'b1;
          r.idx = j[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational grant search: first valid requester at or after ptr, wrapping.
module rr_grant_select
  import rr_mux_pkg::*;
#(
  parameter  int N     = N_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_N'(req_valid), MAX_IDX_W'(ptr), N);
    gnt_idx = IDX_W'(pick.idx);
    gnt_any = pick.any;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-way round-robin arbiter driving a shared mux into a single registered output stage.
// Define RR_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int W     = W_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_src
);

  out_state_t       state_reg;
  logic [W-1:0]     data_reg;
  logic [IDX_W-1:0] src_reg;
  logic [IDX_W-1:0] ptr_sel;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             xfer;
  logic [W-1:0]     req_word [N];

  assign load = (state_reg == ST_EMPTY) || out_ready;
  assign xfer = load && gnt_any;

  // req_ready is gated by rst_n so nothing is accepted while reset is held.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*W +: W];
      assign req_ready[gi] = rst_n && xfer && (gnt_idx == IDX_W'(gi));
    end
  endgenerate

  rr_grant_select #(.N(N)) u_grant (
    .req_valid (req_valid),
    .ptr       (ptr_sel),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_sel = '0;
`else
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  assign ptr_sel  = ptr_reg;
  assign ptr_next = (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + IDX_W'(1);

  // Pointer advances past the winner only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (xfer) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      src_reg   <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (xfer) begin
            state_reg <= ST_FULL;
            data_reg  <= req_word[gnt_idx];
            src_reg   <= gnt_idx;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            data_reg <= req_word[gnt_idx];
            src_reg  <= gnt_idx;
          end else if (out_ready) begin
            state_reg <= ST_EMPTY;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = data_reg;
  assign out_src   = src_reg;

endmodule
